smoldvi_multilane_serialiser: RTL and testbench

SMOLDVI_MULTILANE_SERIALISER -- requirements
Module: smoldvi_multilane_serialiser

---
 rtl/smoldvi_multilane_serialiser.sv | 145 ++++++++++++++
 tb/tb_smoldvi_multilane_serialiser.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smoldvi_multilane_serialiser.sv
// Multi-lane symbol serialiser: one-entry holding buffer feeding per-lane
// shift registers, W_OUT bits per lane per clk_x5, registered P/N outputs.
// Ports: clk_x5/rst_n_x5 clock and async active-low reset; in_valid/in_ready/
// in_data symbol-group handshake; prbs_en test-pattern select; clr_underflow
// and underflow sticky starvation flag; q_p/q_n registered lane outputs.
// Optional feature: define SMOLDVI_SER_PRBS_EN to build the PRBS7 generator.

module smoldvi_multilane_serialiser #(
    parameter int unsigned        N_LANES  = 3,
    parameter int unsigned        W_SYM    = 10,
    parameter int unsigned        W_OUT    = 2,
    parameter logic [W_SYM-1:0]   IDLE_SYM = 10'b1101010100,
    parameter logic [N_LANES-1:0] INV_MASK = '0
) (
    input  logic                       clk_x5,
    input  logic                       rst_n_x5,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_LANES*W_SYM-1:0]   in_data,
    input  logic                       prbs_en,
    input  logic                       clr_underflow,
    output logic                       underflow,
    output logic [N_LANES*W_OUT-1:0]   q_p,
    output logic [N_LANES*W_OUT-1:0]   q_n
);

    localparam int unsigned N_BEATS = W_SYM / W_OUT;
    localparam int unsigned W_BEAT  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [W_BEAT-1:0] LAST_BEAT = W_BEAT'(N_BEATS - 1);

    // Per-lane inversion spread across that lane's output bits.
    function automatic logic [N_LANES*W_OUT-1:0] expand_mask();
        logic [N_LANES*W_OUT-1:0] r;
        r = '0;
        for (int i = 0; i < N_LANES; i++)
            r[i*W_OUT +: W_OUT] = {W_OUT{INV_MASK[i]}};
        return r;
    endfunction

    localparam logic [N_LANES*W_OUT-1:0] INV_BITS = expand_mask();

    logic [W_BEAT-1:0]                 beat_q;
    logic                              last_beat;
    logic [N_LANES-1:0][W_SYM-1:0]     shift_q, shift_d;
    logic [N_LANES-1:0][W_SYM-1:0]     hold_q, hold_d;
    logic                              hold_full_q, hold_full_d;
    logic                              armed_q;
    logic                              xfer;
    logic                              starve;
    logic [N_LANES*W_OUT-1:0]          pre_bits;
    logic [N_LANES*W_OUT-1:0]          q_d;

    assign last_beat = (beat_q == LAST_BEAT);
    assign in_ready  = !hold_full_q;
    assign xfer      = in_valid && in_ready;

    always_comb begin
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        starve      = 1'b0;
        if (last_beat) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (xfer) begin
                shift_d = in_data;
            end else begin
                shift_d = {N_LANES{IDLE_SYM}};
                starve  = armed_q;
            end
        end else begin
            for (int i = 0; i < N_LANES; i++)
                shift_d[i] = shift_q[i] >> W_OUT;
            if (xfer) begin
                hold_d      = in_data;
                hold_full_d = 1'b1;
            end
        end
    end

`ifdef SMOLDVI_SER_PRBS_EN
    // PRBS7 x^7+x^6+1, W_OUT steps per cycle; bit 0 is the first step.
    logic [6:0]       prbs_q, prbs_d;
    logic [W_OUT-1:0] prbs_bits;

    always_comb begin
        prbs_d    = prbs_q;
        prbs_bits = '0;
        for (int j = 0; j < W_OUT; j++) begin
            prbs_bits[j] = prbs_d[6] ^ prbs_d[5];
            prbs_d       = {prbs_d[5:0], prbs_bits[j]};
        end
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5)
            prbs_q <= 7'h7F;
        else
            prbs_q <= prbs_d;
    end
`else
    logic unused_prbs_en;
    assign unused_prbs_en = prbs_en;
`endif

    always_comb begin
        pre_bits = '0;
        for (int i = 0; i < N_LANES; i++)
            pre_bits[i*W_OUT +: W_OUT] = shift_q[i][W_OUT-1:0];
`ifdef SMOLDVI_SER_PRBS_EN
        if (prbs_en)
            pre_bits = {N_LANES{prbs_bits}};
`endif
        q_d = pre_bits ^ INV_BITS;
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            beat_q      <= '0;
            shift_q     <= {N_LANES{IDLE_SYM}};
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            armed_q     <= 1'b0;
            underflow   <= 1'b0;
            q_p         <= INV_BITS;
            q_n         <= ~INV_BITS;
        end else begin
            beat_q      <= last_beat ? '0 : beat_q + W_BEAT'(1);
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            if (xfer)
                armed_q <= 1'b1;
            // A new starvation event outranks a same-cycle clear.
            if (starve)
                underflow <= 1'b1;
            else if (clr_underflow)
                underflow <= 1'b0;
            q_p <= q_d;
            q_n <= ~q_d;
        end
    end

endmodule

// File: tb/tb_smoldvi_multilane_serialiser.sv
// Self-checking bench for smoldvi_multilane_serialiser: directed scenarios
// plus randomized traffic against a symbol-slot timeline model.

module tb_smoldvi_multilane_serialiser;

    localparam int NL = 3;
    localparam int WS = 10;
    localparam int WO = 2;
    localparam int NB = WS / WO;
    localparam int DW = NL * WS;
    localparam int QW = NL * WO;
    localparam logic [NL-1:0] MASK = 3'b010;
    localparam logic [WS-1:0] IDLE = 10'b1101010100;

    logic          clk_x5 = 1'b0;
    logic          rst_n_x5;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          prbs_en;
    logic          clr_underflow;
    logic          underflow;
    logic [QW-1:0] q_p;
    logic [QW-1:0] q_n;

    smoldvi_multilane_serialiser #(
        .N_LANES  (NL),
        .W_SYM    (WS),
        .W_OUT    (WO),
        .IDLE_SYM (IDLE),
        .INV_MASK (MASK)
    ) dut (
        .clk_x5        (clk_x5),
        .rst_n_x5      (rst_n_x5),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .prbs_en       (prbs_en),
        .clr_underflow (clr_underflow),
        .underflow     (underflow),
        .q_p           (q_p),
        .q_n           (q_n)
    );

    always #5 clk_x5 = ~clk_x5;

    int checks = 0;
    int errors = 0;

    // Timeline model: slots[s] is the symbol group occupying output
    // cycles s*NB .. s*NB+NB-1 counted in clock edges since reset.
    int            k;
    logic [DW-1:0] slots[$];
    logic          m_full;
    logic [DW-1:0] m_buf;
    logic          m_armed;
    logic          m_uf;
    logic [QW-1:0] exp_q;
    logic [QW-1:0] mask_bits;
    bit            prbs_seq[$];
    logic [1:0]    idle_tbl[NB] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // PRBS7 sequence from an all-ones seed: b[n] = b[n-7] ^ b[n-6].
    function automatic bit prbs_bit(input int n);
        while (prbs_seq.size() <= n + 7)
            prbs_seq.push_back(prbs_seq[prbs_seq.size()-7] ^
                               prbs_seq[prbs_seq.size()-6]);
        return prbs_seq[n + 7];
    endfunction

    task automatic model_reset();
        k = 0;
        slots.delete();
        slots.push_back({NL{IDLE}});
        m_full  = 1'b0;
        m_buf   = '0;
        m_armed = 1'b0;
        m_uf    = 1'b0;
        exp_q   = mask_bits;
    endtask

    task automatic model_edge();
        logic          xfer;
        logic          starve;
        logic [DW-1:0] cur;
        logic [QW-1:0] pre;
        int            b;
        xfer   = in_valid && !m_full;
        starve = 1'b0;
        cur    = slots[k / NB];
        b      = k % NB;
        for (int i = 0; i < NL; i++)
            pre[i*WO +: WO] = cur[i*WS + WO*b +: WO];
`ifdef SMOLDVI_SER_PRBS_EN
        if (prbs_en)
            for (int i = 0; i < NL; i++)
                for (int j = 0; j < WO; j++)
                    pre[i*WO + j] = prbs_bit(WO*k + j);
`endif
        exp_q = pre ^ mask_bits;
        if (b == NB - 1) begin
            if (m_full) begin
                slots.push_back(m_buf);
                m_full = 1'b0;
            end else if (xfer) begin
                slots.push_back(in_data);
            end else begin
                slots.push_back({NL{IDLE}});
                starve = m_armed;
            end
        end else if (xfer) begin
            m_buf  = in_data;
            m_full = 1'b1;
        end
        if (xfer)
            m_armed = 1'b1;
        if (starve)
            m_uf = 1'b1;
        else if (clr_underflow)
            m_uf = 1'b0;
        k++;
    endtask

    task automatic cycle();
        logic [QW-1:0] nq;
        @(posedge clk_x5);
        model_edge();
        #1;
        nq = ~exp_q;
        chk("q_p", q_p, exp_q);
        chk("q_n", q_n, nq);
        chk("in_ready", in_ready, !m_full);
        chk("underflow", underflow, m_uf);
    endtask

    task automatic do_reset();
        logic [QW-1:0] nm;
        rst_n_x5      = 1'b0;
        in_valid      = 1'b0;
        clr_underflow = 1'b0;
        prbs_en       = 1'b0;
        #2;
        model_reset();
        nm = ~mask_bits;
        chk("rst_q_p", q_p, mask_bits);
        chk("rst_q_n", q_n, nm);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_underflow", underflow, 1'b0);
        @(negedge clk_x5);
        rst_n_x5 = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] byp;
        logic [QW-1:0] byp_q;
        logic [QW-1:0] nm;
        bit            found;

        rst_n_x5      = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        prbs_en       = 1'b0;
        clr_underflow = 1'b0;
        for (int i = 0; i < NL; i++)
            mask_bits[i*WO +: WO] = {WO{MASK[i]}};
        for (int i = 0; i < 7; i++)
            prbs_seq.push_back(1'b1);

        #2;
        do_reset();

        // Idle after reset: lane 0 shows the IDLE pattern, no underflow.
        for (int c = 0; c < 20; c++) begin
            cycle();
            chk("idle_pair", q_p[1:0], idle_tbl[(k-1) % NB]);
        end

        // Continuous traffic with fixed per-lane symbols.
        in_valid = 1'b1;
        in_data  = {10'h155, 10'h0F0, 10'h3A5};
        for (int c = 0; c < 30; c++)
            cycle();

        // Starve; clear pulsed on the cycle underflow sets must lose.
        in_valid = 1'b0;
        found    = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (k % NB == NB - 1 && !m_full && m_armed) begin
                clr_underflow = 1'b1;
                cycle();
                clr_underflow = 1'b0;
                chk("uf_set_wins", underflow, 1'b1);
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("uf_event_seen", found, 1'b1);
        for (int c = 0; c < 12; c++) begin
            clr_underflow = (c == 2);
            cycle();
        end
        clr_underflow = 1'b0;

        // Bypass: transfer offered only on the last beat, buffer empty.
        do_reset();
        for (int c = 0; c < NB - 1; c++)
            cycle();
        byp      = 30'h1234_5678;
        in_valid = 1'b1;
        in_data  = byp;
        cycle();
        in_valid = 1'b0;
        cycle();
        for (int i = 0; i < NL; i++)
            byp_q[i*WO +: WO] = byp[i*WS +: WO] ^ {WO{MASK[i]}};
        chk("bypass_q_p", q_p, byp_q);
        chk("bypass_uf", underflow, 1'b0);
        for (int c = 0; c < 10; c++)
            cycle();

        // Randomized traffic, clears and pattern select.
        for (int c = 0; c < 400; c++) begin
            in_valid      = ($urandom_range(0, 9) < 7);
            in_data       = DW'($urandom());
            clr_underflow = ($urandom_range(0, 9) == 0);
            prbs_en       = ($urandom_range(0, 3) == 0);
            cycle();
        end
        in_valid      = 1'b0;
        clr_underflow = 1'b0;
        prbs_en       = 1'b0;

        // Asynchronous reset at beat 2 with the buffer full.
        do_reset();
        in_valid = 1'b1;
        in_data  = DW'($urandom());
        found    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (k % NB == 2 && m_full) begin
                found = 1'b1;
                break;
            end
        end
        chk("beat2_full_reached", found, 1'b1);
        in_valid = 1'b0;
        rst_n_x5 = 1'b0;
        #1;
        nm = ~mask_bits;
        chk("async_rst_q_p", q_p, mask_bits);
        chk("async_rst_q_n", q_n, nm);
        chk("async_rst_in_ready", in_ready, 1'b1);
        chk("async_rst_uf", underflow, 1'b0);
        do_reset();
        for (int c = 0; c < 12; c++)
            cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
